// File: rtl/mips_insn_encoder.sv
// Streaming MIPS instruction encoder: accepts symbolic instructions one at a time,
// encodes them into 32-bit words and writes them sequentially into instruction
// memory starting at BASE_ADDR. Expands `li` into one or two words.
module mips_insn_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int unsigned IM_AW     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op_id,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic [4:0]       shamt,
  input  logic [31:0]      imm,
  output logic             im_we,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      im_wdata,
  output logic [31:0]      pc_cur,
  output logic [IM_AW:0]   count,
  output logic             full,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam logic [IM_AW:0] DepthCnt = {1'b1, {IM_AW{1'b0}}};
  localparam logic [IM_AW:0] LastSlot = DepthCnt - 1'b1;

  localparam logic [4:0] OpNop  = 5'd0;
  localparam logic [4:0] OpAddu = 5'd1;
  localparam logic [4:0] OpSubu = 5'd2;
  localparam logic [4:0] OpJr   = 5'd3;
  localparam logic [4:0] OpSll  = 5'd4;
  localparam logic [4:0] OpSlt  = 5'd5;
  localparam logic [4:0] OpJalr = 5'd6;
  localparam logic [4:0] OpOri  = 5'd7;
  localparam logic [4:0] OpLw   = 5'd8;
  localparam logic [4:0] OpSw   = 5'd9;
  localparam logic [4:0] OpBeq  = 5'd10;
  localparam logic [4:0] OpLui  = 5'd11;
  localparam logic [4:0] OpJal  = 5'd12;
  localparam logic [4:0] OpJ    = 5'd13;
  localparam logic [4:0] OpSh   = 5'd14;
  localparam logic [4:0] OpLb   = 5'd15;
  localparam logic [4:0] OpBgtz = 5'd16;
  localparam logic [4:0] OpLi   = 5'd17;

  localparam logic [1:0] ErrNone  = 2'd0;
  localparam logic [1:0] ErrOp    = 2'd1;
  localparam logic [1:0] ErrRange = 2'd2;
  localparam logic [1:0] ErrOvf   = 2'd3;

  typedef enum logic [1:0] {StIdle, StEmit2, StHalt} state_e;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [IM_AW-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      pc_q, pc_d;
  logic [IM_AW:0]   count_q, count_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [4:0]       li_rt_q, li_rt_d;
  logic [15:0]      li_lo_q, li_lo_d;

  // Address arithmetic shared by branches and jumps; pc_q is the address of the word
  // about to be written, so the delay-slot base is pc_q + 4.
  logic [31:0] pc_next;
  logic [31:0] br_diff;
  logic        br_range_ok;
  logic        mem_ok;
  logic        jmp_ok;
  logic        align_ok;

  assign pc_next     = pc_q + 32'd4;
  assign br_diff     = imm - pc_next;
  // Offset is br_diff >>> 2; it fits 16 signed bits when bits 31..17 are a sign run.
  assign br_range_ok = (br_diff[31:17] == {15{br_diff[17]}});
  assign mem_ok      = (imm[31:15] == {17{imm[15]}});
  assign jmp_ok      = (imm[31:28] == pc_next[31:28]);
  assign align_ok    = (imm[1:0] == 2'b00);

  logic [31:0] enc_word;
  logic [1:0]  enc_code;
  logic        enc_two;

  // Combinational encoding of the presented fields and field-level error checks.
  always_comb begin
    enc_word = '0;
    enc_code = ErrNone;
    enc_two  = 1'b0;
    case (op_id)
      OpNop:  enc_word = '0;
      OpAddu: enc_word = {6'b000000, rs, rt, rd, 5'b0, 6'b100001};
      OpSubu: enc_word = {6'b000000, rs, rt, rd, 5'b0, 6'b100011};
      OpJr:   enc_word = {6'b000000, rs, 5'b0, 5'b0, 5'b0, 6'b001000};
      OpSll:  enc_word = {6'b000000, 5'b0, rt, rd, shamt, 6'b000000};
      OpSlt:  enc_word = {6'b000000, rs, rt, rd, 5'b0, 6'b101010};
      OpJalr: enc_word = {6'b000000, rs, 5'b0, rd, 5'b0, 6'b001001};
      OpOri:  enc_word = {6'b001101, rs, rt, imm[15:0]};
      OpLui:  enc_word = {6'b001111, 5'b0, rt, imm[15:0]};
      OpLw, OpSw, OpSh, OpLb: begin
        case (op_id)
          OpLw:    enc_word = {6'b100011, rs, rt, imm[15:0]};
          OpSw:    enc_word = {6'b101011, rs, rt, imm[15:0]};
          OpSh:    enc_word = {6'b101001, rs, rt, imm[15:0]};
          default: enc_word = {6'b100000, rs, rt, imm[15:0]};
        endcase
        if (!mem_ok) enc_code = ErrRange;
      end
      OpBeq, OpBgtz: begin
        if (op_id == OpBeq) enc_word = {6'b000100, rs, rt, br_diff[17:2]};
        else                enc_word = {6'b000111, rs, 5'b0, br_diff[17:2]};
        if (!align_ok || !br_range_ok) enc_code = ErrRange;
      end
      OpJ, OpJal: begin
        if (op_id == OpJ) enc_word = {6'b000010, imm[27:2]};
        else              enc_word = {6'b000011, imm[27:2]};
        if (!align_ok || !jmp_ok) enc_code = ErrRange;
      end
      OpLi: begin
        if (imm[31:16] == 16'h0) begin
          enc_word = {6'b001101, 5'b0, rt, imm[15:0]};
        end else begin
          enc_word = {6'b001111, 5'b0, rt, imm[31:16]};
          enc_two  = (imm[15:0] != 16'h0);
        end
      end
      default: enc_code = ErrOp;
    endcase
  end

  assign in_ready = (state_q == StIdle) && !full;

  // Next-state logic: acceptance, write generation, error capture.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    count_d = count_q;
    err_d   = err_q;
    code_d  = code_q;
    li_rt_d = li_rt_q;
    li_lo_d = li_lo_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && full) begin
          err_d   = 1'b1;
          code_d  = ErrOvf;
          state_d = StHalt;
        end else if (in_valid) begin
          if (enc_code != ErrNone) begin
            err_d   = 1'b1;
            code_d  = enc_code;
            state_d = StHalt;
          end else if (enc_two && (count_q == LastSlot)) begin
            // No room for the trailing ori: reject the whole li, write nothing.
            err_d   = 1'b1;
            code_d  = ErrOvf;
            state_d = StHalt;
          end else begin
            we_d    = 1'b1;
            addr_d  = count_q[IM_AW-1:0];
            wdata_d = enc_word;
            pc_d    = pc_next;
            count_d = count_q + 1'b1;
            if (enc_two) begin
              li_rt_d = rt;
              li_lo_d = imm[15:0];
              state_d = StEmit2;
            end
          end
        end
      end
      StEmit2: begin
        we_d    = 1'b1;
        addr_d  = count_q[IM_AW-1:0];
        wdata_d = {6'b001101, li_rt_q, li_rt_q, li_lo_q};
        pc_d    = pc_next;
        count_d = count_q + 1'b1;
        state_d = StIdle;
      end
      StHalt: state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= BASE_ADDR;
      count_q <= '0;
      err_q   <= 1'b0;
      code_q  <= ErrNone;
      li_rt_q <= '0;
      li_lo_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      err_q   <= err_d;
      code_q  <= code_d;
      li_rt_q <= li_rt_d;
      li_lo_q <= li_lo_d;
    end
  end

  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign pc_cur   = pc_q;
  assign count    = count_q;
  assign full     = (count_q == DepthCnt);
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_mips_insn_encoder.sv
// Directed, table-driven bench for mips_insn_encoder: a default-size instance for
// encoding/error checks and an IM_AW=2 instance for capacity corner cases.
module tb_mips_insn_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  op_id = '0, rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [31:0] imm = '0;

  logic        in_ready, im_we, full, err;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata, pc_cur;
  logic [10:0] count;
  logic [1:0]  err_code;

  logic        s_in_ready, s_im_we, s_full, s_err;
  logic [1:0]  s_im_addr;
  logic [31:0] s_im_wdata, s_pc_cur;
  logic [2:0]  s_count;
  logic [1:0]  s_err_code;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_insn_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_id(op_id), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .pc_cur(pc_cur),
    .count(count), .full(full), .err(err), .err_code(err_code)
  );

  mips_insn_encoder #(.BASE_ADDR(32'h0000_3000), .IM_AW(2)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .op_id(op_id), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .im_we(s_im_we), .im_addr(s_im_addr), .im_wdata(s_im_wdata), .pc_cur(s_pc_cur),
    .count(s_count), .full(s_full), .err(s_err), .err_code(s_err_code)
  );

  typedef struct {
    logic [4:0]  op, rs, rt, rd, sh;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] imm;
    logic [1:0]  code;
  } evec_t;

  vec_t  vecs[20];
  evec_t evecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the reset edge.
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Presents fields for exactly one rising edge; returns at the following negedge.
  task automatic drive(input logic [4:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [4:0] h, input logic [31:0] i);
    @(negedge clk);
    op_id = o; rs = s; rt = t; rd = d; shamt = h; imm = i;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_im_wdata", im_wdata, 32'd0);
    chk("rst_pc_cur", pc_cur, 32'h3000);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
  endtask

  initial begin
    // op, rs, rt, rd, shamt, imm, expected word; issued back to back from reset
    vecs[0]  = '{5'd7,  5'd0,  5'd1, 5'd0,  5'd0, 32'h0000_1234, 32'h3401_1234}; // ori
    vecs[1]  = '{5'd10, 5'd1,  5'd2, 5'd0,  5'd0, 32'h0000_3000, 32'h1022_FFFE}; // beq -2
    vecs[2]  = '{5'd12, 5'd0,  5'd0, 5'd0,  5'd0, 32'h0000_3000, 32'h0C00_0C00}; // jal
    vecs[3]  = '{5'd1,  5'd1,  5'd2, 5'd3,  5'd0, 32'h0,         32'h0022_1821}; // addu
    vecs[4]  = '{5'd2,  5'd4,  5'd5, 5'd6,  5'd0, 32'h0,         32'h0085_3023}; // subu
    vecs[5]  = '{5'd4,  5'd7,  5'd2, 5'd3,  5'd4, 32'h0,         32'h0002_1900}; // sll
    vecs[6]  = '{5'd3,  5'd31, 5'd1, 5'd1,  5'd3, 32'h0,         32'h03E0_0008}; // jr
    vecs[7]  = '{5'd5,  5'd1,  5'd2, 5'd3,  5'd0, 32'h0,         32'h0022_182A}; // slt
    vecs[8]  = '{5'd6,  5'd2,  5'd5, 5'd31, 5'd0, 32'h0,         32'h0040_F809}; // jalr
    vecs[9]  = '{5'd8,  5'd29, 5'd8, 5'd0,  5'd0, 32'hFFFF_FFFC, 32'h8FA8_FFFC}; // lw
    vecs[10] = '{5'd9,  5'd29, 5'd9, 5'd0,  5'd0, 32'h0000_0004, 32'hAFA9_0004}; // sw
    vecs[11] = '{5'd14, 5'd1,  5'd2, 5'd0,  5'd0, 32'h0000_0010, 32'hA422_0010}; // sh
    vecs[12] = '{5'd15, 5'd3,  5'd4, 5'd0,  5'd0, 32'h0000_7FFF, 32'h8064_7FFF}; // lb
    vecs[13] = '{5'd11, 5'd3,  5'd5, 5'd0,  5'd0, 32'hABCD_1234, 32'h3C05_1234}; // lui
    vecs[14] = '{5'd0,  5'd9,  5'd9, 5'd9,  5'd9, 32'hFFFF_FFFF, 32'h0000_0000}; // nop
    vecs[15] = '{5'd13, 5'd0,  5'd0, 5'd0,  5'd0, 32'h0000_3000, 32'h0800_0C00}; // j
    vecs[16] = '{5'd16, 5'd3,  5'd7, 5'd0,  5'd0, 32'h0000_3050, 32'h1C60_0003}; // bgtz +3
    vecs[17] = '{5'd7,  5'd2,  5'd3, 5'd0,  5'd0, 32'hFFFF_0001, 32'h3443_0001}; // ori hi ign
    vecs[18] = '{5'd17, 5'd0,  5'd4, 5'd0,  5'd0, 32'h0000_5678, 32'h3404_5678}; // li low
    vecs[19] = '{5'd17, 5'd0,  5'd6, 5'd0,  5'd0, 32'h0012_0000, 32'h3C06_0012}; // li high

    // Errors from a fresh reset (pc = 0x3000)
    evecs[0] = '{5'd10, 32'h0000_3002, 2'd2}; // misaligned branch
    evecs[1] = '{5'd20, 32'h0,         2'd1}; // unsupported op
    evecs[2] = '{5'd10, 32'h0002_3004, 2'd2}; // offset +0x8000 out of range
    evecs[3] = '{5'd12, 32'h1000_0000, 2'd2}; // jump region mismatch
    evecs[4] = '{5'd8,  32'h0000_8000, 2'd2}; // lw offset not sign-extendable
    evecs[5] = '{5'd13, 32'h0000_3001, 2'd2}; // misaligned jump
    evecs[6] = '{5'd16, 32'h0000_3006, 2'd2}; // misaligned bgtz

    do_reset();
    chk_reset_state();

    for (int i = 0; i < 20; i++) begin
      chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'd1);
      drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm);
      chk($sformatf("v%0d_we", i), 32'(im_we), 32'd1);
      chk($sformatf("v%0d_addr", i), 32'(im_addr), 32'(i));
      chk($sformatf("v%0d_wdata", i), im_wdata, vecs[i].word);
      chk($sformatf("v%0d_pc", i), pc_cur, 32'h3000 + 32'(4 * (i + 1)));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(i + 1));
    end

    // Write strobe is a single cycle
    @(negedge clk);
    chk("we_pulse", 32'(im_we), 32'd0);

    // Two-word li at address 20
    drive(5'd17, 5'd0, 5'd4, 5'd0, 5'd0, 32'h1234_5678);
    chk("li2_lui_we", 32'(im_we), 32'd1);
    chk("li2_lui_addr", 32'(im_addr), 32'd20);
    chk("li2_lui_word", im_wdata, 32'h3C04_1234);
    chk("li2_emit2_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("li2_ori_we", 32'(im_we), 32'd1);
    chk("li2_ori_addr", 32'(im_addr), 32'd21);
    chk("li2_ori_word", im_wdata, 32'h3484_5678);
    chk("li2_count", 32'(count), 32'd22);
    chk("li2_pc", pc_cur, 32'h3058);
    chk("li2_ready_after", 32'(in_ready), 32'd1);

    // Misaligned branch halts the encoder until reset
    drive(5'd10, 5'd1, 5'd2, 5'd0, 5'd0, 32'h0000_3002);
    chk("halt_err", 32'(err), 32'd1);
    chk("halt_code", 32'(err_code), 32'd2);
    chk("halt_we", 32'(im_we), 32'd0);
    drive(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
    repeat (2) @(negedge clk);
    chk("halt_ready", 32'(in_ready), 32'd0);
    chk("halt_count", 32'(count), 32'd22);
    chk("halt_we_hold", 32'(im_we), 32'd0);

    do_reset();
    chk_reset_state();

    for (int i = 0; i < 7; i++) begin
      do_reset();
      drive(evecs[i].op, 5'd1, 5'd2, 5'd3, 5'd0, evecs[i].imm);
      chk($sformatf("e%0d_err", i), 32'(err), 32'd1);
      chk($sformatf("e%0d_code", i), 32'(err_code), 32'(evecs[i].code));
      chk($sformatf("e%0d_we", i), 32'(im_we), 32'd0);
      chk($sformatf("e%0d_count", i), 32'(count), 32'd0);
      chk($sformatf("e%0d_ready", i), 32'(in_ready), 32'd0);
    end

    // Reset in EMIT2 discards the pending ori
    do_reset();
    drive(5'd17, 5'd0, 5'd4, 5'd0, 5'd0, 32'h1234_5678);
    chk("rstmid_lui_word", im_wdata, 32'h3C04_1234);
    do_reset();
    chk("rstmid_we", 32'(im_we), 32'd0);
    chk("rstmid_count", 32'(count), 32'd0);
    @(negedge clk);
    chk("rstmid_we_later", 32'(im_we), 32'd0);
    chk("rstmid_count_later", 32'(count), 32'd0);

    // Small instance: fill all 4 slots
    do_reset();
    for (int i = 0; i < 4; i++) drive(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
    chk("s_full", 32'(s_full), 32'd1);
    chk("s_count4", 32'(s_count), 32'd4);
    chk("s_last_addr", 32'(s_im_addr), 32'd3);
    chk("s_last_we", 32'(s_im_we), 32'd1);
    chk("s_ready_full", 32'(s_in_ready), 32'd0);
    drive(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
    chk("s_ovf_err", 32'(s_err), 32'd1);
    chk("s_ovf_code", 32'(s_err_code), 32'd3);
    chk("s_ovf_we", 32'(s_im_we), 32'd0);
    chk("s_ovf_count", 32'(s_count), 32'd4);

    // Two-word li with a single slot left is rejected whole
    do_reset();
    for (int i = 0; i < 3; i++) drive(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 32'h0);
    chk("s_count3", 32'(s_count), 32'd3);
    chk("s_not_full", 32'(s_full), 32'd0);
    drive(5'd17, 5'd0, 5'd4, 5'd0, 5'd0, 32'h1234_5678);
    chk("s_li_err", 32'(s_err), 32'd1);
    chk("s_li_code", 32'(s_err_code), 32'd3);
    chk("s_li_we", 32'(s_im_we), 32'd0);
    chk("s_li_count", 32'(s_count), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_insn_encoder.md
Name: mips_insn_encoder

Overview:
- Streaming encoder for the P4 instruction set: it is the encode-direction counterpart of the CPU's instruction decoder. It turns symbolic instructions (op id, register fields, immediate/target) into 32-bit MIPS words.
- Encoded words are written sequentially into instruction memory starting at BASE_ADDR, for self-checking program loading in testbenches and boot.
- It computes PC-relative branch offsets and pseudo-direct jump fields, and expands the `li` pseudo-instruction into one or two words.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address of the first emitted word.
- IM_AW, 10, instruction memory word-address width; DEPTH = 2^IM_AW words.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction fields are valid
- in_ready  out  1  encoder accepts the fields this cycle
- op_id  in  5  0 nop, 1 addu, 2 subu, 3 jr, 4 sll, 5 slt, 6 jalr, 7 ori, 8 lw, 9 sw, 10 beq, 11 lui, 12 jal, 13 j, 14 sh, 15 lb, 16 bgtz, 17 li; 18-31 unsupported
- rs, rt, rd, shamt  in  5 each  register/shift fields
- imm  in  32  immediate, memory offset, or branch/jump target byte address
- im_we  out  1  instruction memory write strobe
- im_addr  out  IM_AW  word address of the write
- im_wdata  out  32  encoded word
- pc_cur  out  32  byte address of the next word to be written
- count  out  IM_AW+1  words written so far
- full  out  1  count == DEPTH
- err  out  1  sticky error flag
- err_code  out  2  1 unsupported op, 2 range/alignment, 3 overflow

Behaviour:
- Reset values: in_ready=1, im_we=0, im_addr=0, im_wdata=0, pc_cur=BASE_ADDR, count=0, full=0, err=0, err_code=0. State is IDLE.
- Handshake: a transfer occurs when in_valid && in_ready. Fields are sampled at that edge.
- Latency: im_we/im_addr/im_wdata are registered and asserted for exactly 1 cycle, in the cycle after acceptance. Then pc_cur += 4 and count += 1 for each written word.
- FSM states: IDLE, EMIT2, HALT.
- IDLE: in_ready = !full.
  - Single-word ops write one word and remain in IDLE.
  - `li` with imm[31:16]==0: emits `ori rt,$0,imm[15:0]`.
  - `li` with imm[15:0]==0: emits `lui rt,imm[31:16]`.
  - Otherwise `li` emits `lui rt,imm[31:16]`, then goes to EMIT2.
- EMIT2: in_ready=0. Emits `ori rt,rt,imm[15:0]` using the latched rt/imm, writing one cycle after the lui. Returns to IDLE.
- HALT: entered on any error. in_ready=0, no writes. Leaves only on reset.
- Encoding:
  - R-type ops: op=0, with funct addu 100001, subu 100011, jr 001000, sll 000000, slt 101010, jalr 001001.
  - sll: rs=0, shamt from input. jr: rt=rd=shamt=0. jalr: rt=0.
  - nop encodes as 32'h0 regardless of the other fields.
  - I-type opcodes: ori 001101, lui 001111 (rs=0), lw 100011, sw 101011, sh 101001, lb 100000. These use imm[15:0].
  - beq 000100, bgtz 000111 (rt=0): offset = (imm − (pc+4)) >>> 2, where pc is the address of the branch word.
  - j 000010, jal 000011: index = imm[27:2].
- Errors: detected at acceptance. Nothing is written for the offending input; err/err_code are set the next cycle.
  - err_code 1: op_id ≥ 18.
  - err_code 2: branch/jump imm[1:0]≠0; branch offset outside signed 16 bits; jump with imm[31:28]≠(pc+4)[31:28]; memory op with imm not sign-extendable from 16 bits. ori/lui ignore imm[31:16].
  - err_code 3: in_valid while full. Or a two-word `li` accepted with only one slot left; that `li` is rejected whole, with no partial lui.
- Wrap-around: im_addr never wraps. The word at DEPTH−1 is the last one written, and full asserts the cycle after it.
- Reset mid-operation, including mid-EMIT2: all state returns to reset values and the pending ori is discarded.

Test Plan:
- Reset, then addu rs=1 rt=2 rd=3 -> one cycle later im_we=1, im_addr=0, im_wdata=0x00221821; pc_cur=0x3004, count=1.
- From reset: ori rt=1 rs=0 imm=0x1234, then beq rs=1 rt=2 imm=0x3000 -> writes 0x34011234 at addr 0, then 0x1022FFFE at addr 1 (offset −2).
- li rt=4 imm=0x12345678 -> 0x3C041234 then 0x34845678 on consecutive cycles; in_ready=0 during EMIT2. li imm=0x00005678 -> single word 0x34045678.
- From reset: jal imm=0x3000 as the third instruction -> 0x0C000C00. beq imm=0x3002 -> err=1, err_code=2, no write, in_ready=0 until reset.
- op_id=20 -> err_code=1. Reset during EMIT2 -> ori never written, count=0.
- IM_AW=2: emit 4 addu -> full=1. A 5th in_valid -> err_code=3. With 3 words filled, a two-word li -> err_code=3 and count stays 3.
